// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Two-port round-robin arbiter/sequencer in front of a single-ported
//            64Ki x 32 on-chip RAM. Each access is a fixed three-cycle
//            transaction (IDLE -> ISSUE -> DONE); contended grants alternate.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    // Port 0 (CPU native memory interface)
    input  logic              m0_valid,
    input  logic [31:0]       m0_addr,
    input  logic [3:0]        m0_wstrb,
    input  logic [31:0]       m0_wdata,
    output logic              m0_ready,
    output logic [31:0]       m0_rdata,
    // Port 1 (secondary master)
    input  logic              m1_valid,
    input  logic [31:0]       m1_addr,
    input  logic [3:0]        m1_wstrb,
    input  logic [31:0]       m1_wdata,
    output logic              m1_ready,
    output logic [31:0]       m1_rdata,
    // RAM side
    output logic              ram_ce,
    output logic [3:0]        ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_d,
    input  logic [31:0]       ram_q
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q;
    logic                last_grant_q;
    logic                grant_q;
    logic                ram_ce_q;
    logic [3:0]          ram_wr_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [31:0]         ram_d_q;
    logic                m0_ready_q;
    logic                m1_ready_q;

    logic                grant_d;
    logic                req_any_d;
    logic [ADDR_W-1:0]   sel_addr_d;
    logic [3:0]          sel_wstrb_d;
    logic [31:0]         sel_wdata_d;

    // Arbitration decision: a lone requester wins; on contention the port
    // that was not granted last time wins.
    always_comb begin
        req_any_d   = m0_valid | m1_valid;
        grant_d     = m1_valid & (~m0_valid | ~last_grant_q);
        sel_addr_d  = grant_d ? m1_addr[ADDR_W+1:2] : m0_addr[ADDR_W+1:2];
        sel_wstrb_d = grant_d ? m1_wstrb : m0_wstrb;
        sel_wdata_d = grant_d ? m1_wdata : m0_wdata;
    end

    // Transaction sequencer with registered RAM controls and ready pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            ram_ce_q     <= 1'b0;
            ram_wr_q     <= 4'b0000;
            ram_addr_q   <= '0;
            ram_d_q      <= 32'd0;
            m0_ready_q   <= 1'b0;
            m1_ready_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    m0_ready_q <= 1'b0;
                    m1_ready_q <= 1'b0;
                    if (req_any_d) begin
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        ram_ce_q     <= 1'b1;
                        ram_wr_q     <= sel_wstrb_d;
                        ram_addr_q   <= sel_addr_d;
                        ram_d_q      <= sel_wdata_d;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // RAM samples ce/wr/addr/d on this edge; q is valid in DONE.
                    ram_ce_q   <= 1'b0;
                    ram_wr_q   <= 4'b0000;
                    m0_ready_q <= ~grant_q;
                    m1_ready_q <= grant_q;
                    state_q    <= S_DONE;
                end
                S_DONE: begin
                    m0_ready_q <= 1'b0;
                    m1_ready_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    ram_ce_q   <= 1'b0;
                    ram_wr_q   <= 4'b0000;
                    m0_ready_q <= 1'b0;
                    m1_ready_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign ram_ce   = ram_ce_q;
    assign ram_wr   = ram_wr_q;
    assign ram_addr = ram_addr_q;
    assign ram_d    = ram_d_q;
    assign m0_ready = m0_ready_q;
    assign m1_ready = m1_ready_q;

    // Read data is a straight passthrough of the RAM output register.
    assign m0_rdata = ram_q;
    assign m1_rdata = ram_q;

    // Byte-lane and out-of-range address bits are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr[31:ADDR_W+2], m0_addr[1:0],
                                m1_addr[31:ADDR_W+2], m1_addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Self-checking bench for ram_arbiter with a behavioural RAM and a
//            transaction-level reference memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int ADDR_W = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic        ram_ce;
    logic [3:0]  ram_wr;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0] ram_d;
    logic [31:0] ram_q;

    // Backdoor preload path into the behavioural RAM
    logic        bd_en;
    logic [15:0] bd_addr;
    logic [31:0] bd_data;

    logic [31:0] mem     [0:65535];
    logic [31:0] ref_mem [0:65535];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_valid (m0_valid),
        .m0_addr  (m0_addr),
        .m0_wstrb (m0_wstrb),
        .m0_wdata (m0_wdata),
        .m0_ready (m0_ready),
        .m0_rdata (m0_rdata),
        .m1_valid (m1_valid),
        .m1_addr  (m1_addr),
        .m1_wstrb (m1_wstrb),
        .m1_wdata (m1_wdata),
        .m1_ready (m1_ready),
        .m1_rdata (m1_rdata),
        .ram_ce   (ram_ce),
        .ram_wr   (ram_wr),
        .ram_addr (ram_addr),
        .ram_d    (ram_d),
        .ram_q    (ram_q)
    );

    // Single-ported RAM: registered read-before-write, byte-masked writes.
    always @(posedge clk) begin
        if (bd_en) begin
            mem[bd_addr] <= bd_data;
        end else if (ram_ce) begin
            ram_q <= mem[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_wr[b]) mem[ram_addr][8*b +: 8] <= ram_d[8*b +: 8];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_valid = 1'b0; m0_addr = 32'd0; m0_wstrb = 4'd0; m0_wdata = 32'd0;
        m1_valid = 1'b0; m1_addr = 32'd0; m1_wstrb = 4'd0; m1_wdata = 32'd0;
    endtask

    task automatic preload(input logic [15:0] a, input logic [31:0] d);
        bd_en = 1'b1; bd_addr = a; bd_data = d;
        step();
        bd_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic preload_block();
        for (int i = 0; i < 16; i++) preload(16'h0020 + 16'(i), $urandom());
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    // Random request over words 0x20..0x2F with junk in the ignored address bits.
    task automatic gen_req(output logic [31:0] a, output logic [15:0] w,
                           output logic [3:0] ws, output logic [31:0] wd);
        logic [31:0] r;
        r  = $urandom();
        w  = 16'h0020 + 16'($urandom_range(0, 15));
        a  = (r & 32'hFFFC_0003) | {14'd0, w, 2'b00};
        ws = ($urandom_range(0, 1) == 1) ? 4'($urandom()) : 4'b0000;
        wd = $urandom();
    endtask

    // Reference access: returns the pre-write word, then applies the byte write.
    task automatic ref_access(input logic [15:0] w, input logic [3:0] ws,
                              input logic [31:0] wd, output logic [31:0] old);
        old = ref_mem[w];
        for (int b = 0; b < 4; b++)
            if (ws[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        m0_valid = 1'b1; m0_addr = 32'h0000_0040; m1_valid = 1'b1;
        step(); step(); step();
        n_checks++; if (ram_ce !== 1'b0) $display("FAIL reset_ce got %b want 0", ram_ce); else n_pass++;
        n_checks++; if (ram_wr !== 4'd0) $display("FAIL reset_wr got %h want 0", ram_wr); else n_pass++;
        n_checks++; if (ram_addr !== 16'd0) $display("FAIL reset_addr got %h want 0", ram_addr); else n_pass++;
        n_checks++; if (ram_d !== 32'd0) $display("FAIL reset_d got %h want 0", ram_d); else n_pass++;
        n_checks++; if ({m0_ready, m1_ready} !== 2'b00) $display("FAIL reset_ready got %b want 00", {m0_ready, m1_ready}); else n_pass++;
        idle_inputs();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        preload(16'h0010, 32'hDEAD_BEEF);
        m0_valid = 1'b1; m0_addr = 32'h0000_0040; m0_wstrb = 4'd0; m0_wdata = $urandom();
        n_checks++; if (ram_ce !== 1'b0) $display("FAIL rd_ce_c0 got %b want 0", ram_ce); else n_pass++;
        for (int t = 1; t <= 3; t++) begin
            step();
            n_checks++; if (ram_ce !== (t == 1)) $display("FAIL rd_ce_c%0d got %b want %b", t, ram_ce, (t == 1)); else n_pass++;
            n_checks++; if (m0_ready !== (t == 2)) $display("FAIL rd_m0rdy_c%0d got %b want %b", t, m0_ready, (t == 2)); else n_pass++;
            n_checks++; if (m1_ready !== 1'b0) $display("FAIL rd_m1rdy_c%0d got %b want 0", t, m1_ready); else n_pass++;
            if (t == 1) begin
                n_checks++; if (ram_addr !== 16'h0010 || ram_wr !== 4'd0) $display("FAIL rd_issue got addr %h wr %h want 0010 0", ram_addr, ram_wr); else n_pass++;
            end
            if (t == 2) begin
                n_checks++; if (m0_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_data got %h want deadbeef", m0_rdata); else n_pass++;
                m0_valid = 1'b0;
            end
        end
    endtask

    task automatic test_byte_write();
        preload(16'h0011, 32'h1122_3344);
        m1_valid = 1'b1; m1_addr = 32'h0000_0044; m1_wstrb = 4'b0100; m1_wdata = 32'h00AB_0000;
        for (int t = 1; t <= 6; t++) begin
            step();
            n_checks++; if (ram_ce !== (t == 1 || t == 4)) $display("FAIL bw_ce_c%0d got %b", t, ram_ce); else n_pass++;
            n_checks++; if (m1_ready !== (t == 2 || t == 5)) $display("FAIL bw_m1rdy_c%0d got %b", t, m1_ready); else n_pass++;
            n_checks++; if (m0_ready !== 1'b0) $display("FAIL bw_m0rdy_c%0d got %b want 0", t, m0_ready); else n_pass++;
            if (t == 1) begin
                n_checks++; if (ram_wr !== 4'b0100 || ram_d !== 32'h00AB_0000) $display("FAIL bw_issue got wr %b d %h want 0100 00ab0000", ram_wr, ram_d); else n_pass++;
            end
            if (t == 2) begin
                n_checks++; if (m1_rdata !== 32'h1122_3344) $display("FAIL bw_prewrite got %h want 11223344", m1_rdata); else n_pass++;
            end
            if (t == 3) begin
                m1_wstrb = 4'b0000; m1_wdata = 32'd0;
            end
            if (t == 5) begin
                n_checks++; if (m1_rdata !== 32'h11AB_3344) $display("FAIL bw_readback got %h want 11ab3344", m1_rdata); else n_pass++;
                m1_valid = 1'b0;
            end
        end
        ref_mem[16'h0011] = 32'h11AB_3344;
    endtask

    task automatic test_addr_mask();
        logic [31:0] v;
        v = $urandom();
        preload(16'h0010, v);
        m0_valid = 1'b1; m0_addr = 32'hFFFC_0043; m0_wstrb = 4'd0;
        for (int t = 1; t <= 3; t++) begin
            step();
            if (t == 1) begin
                n_checks++; if (ram_addr !== 16'h0010) $display("FAIL mask_addr got %h want 0010", ram_addr); else n_pass++;
            end
            if (t == 2) begin
                n_checks++; if (m0_ready !== 1'b1 || m0_rdata !== v) $display("FAIL mask_data got rdy %b data %h want 1 %h", m0_ready, m0_rdata, v); else n_pass++;
                m0_valid = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, wd, exp;
        logic [15:0] w;
        logic [3:0]  ws;
        preload_block();
        for (int k = 0; k < 8; k++) begin
            gen_req(a, w, ws, wd);
            ref_access(w, ws, wd, exp);
            m0_valid = 1'b1; m0_addr = a; m0_wstrb = ws; m0_wdata = wd;
            step();
            n_checks++; if (ram_ce !== 1'b1 || ram_addr !== w || ram_wr !== ws) $display("FAIL b2b_issue_%0d got ce %b addr %h wr %h want 1 %h %h", k, ram_ce, ram_addr, ram_wr, w, ws); else n_pass++;
            if (ws != 4'd0) begin
                n_checks++; if (ram_d !== wd) $display("FAIL b2b_wdata_%0d got %h want %h", k, ram_d, wd); else n_pass++;
            end
            step();
            n_checks++; if (ram_ce !== 1'b0 || m0_ready !== 1'b1 || m1_ready !== 1'b0) $display("FAIL b2b_done_%0d got ce %b rdy %b%b want 0 10", k, ram_ce, m0_ready, m1_ready); else n_pass++;
            n_checks++; if (m0_rdata !== exp) $display("FAIL b2b_data_%0d got %h want %h", k, m0_rdata, exp); else n_pass++;
            step();
            n_checks++; if (ram_ce !== 1'b0 || m0_ready !== 1'b0) $display("FAIL b2b_idle_%0d got ce %b rdy %b want 0 0", k, ram_ce, m0_ready); else n_pass++;
        end
        m0_valid = 1'b0;
    endtask

    task automatic test_contention();
        logic [31:0] ra  [2][4];
        logic [15:0] rw  [2][4];
        logic [3:0]  rws [2][4];
        logic [31:0] rwd [2][4];
        logic [31:0] exp, got_data;
        logic        got_rdy_w, got_rdy_o;
        int          w, i;
        preload_block();
        for (int p = 0; p < 2; p++)
            for (int j = 0; j < 4; j++) gen_req(ra[p][j], rw[p][j], rws[p][j], rwd[p][j]);
        do_reset();
        m0_valid = 1'b1; m0_addr = ra[0][0]; m0_wstrb = rws[0][0]; m0_wdata = rwd[0][0];
        m1_valid = 1'b1; m1_addr = ra[1][0]; m1_wstrb = rws[1][0]; m1_wdata = rwd[1][0];
        for (int k = 0; k < 8; k++) begin
            // Both ports always pending, so service strictly alternates from port 0.
            w = k % 2;
            i = k / 2;
            ref_access(rw[w][i], rws[w][i], rwd[w][i], exp);
            step();
            n_checks++; if (ram_ce !== 1'b1 || ram_addr !== rw[w][i] || ram_wr !== rws[w][i]) $display("FAIL cont_issue_%0d got ce %b addr %h wr %h want 1 %h %h", k, ram_ce, ram_addr, ram_wr, rw[w][i], rws[w][i]); else n_pass++;
            step();
            got_rdy_w = (w == 0) ? m0_ready : m1_ready;
            got_rdy_o = (w == 0) ? m1_ready : m0_ready;
            got_data  = (w == 0) ? m0_rdata : m1_rdata;
            n_checks++; if (got_rdy_w !== 1'b1 || got_rdy_o !== 1'b0) $display("FAIL cont_grant_%0d port %0d got rdy %b other %b want 1 0", k, w, got_rdy_w, got_rdy_o); else n_pass++;
            n_checks++; if (got_data !== exp) $display("FAIL cont_data_%0d got %h want %h", k, got_data, exp); else n_pass++;
            step();
            n_checks++; if ({m0_ready, m1_ready} !== 2'b00 || ram_ce !== 1'b0) $display("FAIL cont_idle_%0d got rdy %b%b ce %b want 00 0", k, m0_ready, m1_ready, ram_ce); else n_pass++;
            if (w == 0) begin
                if (i < 3) begin m0_addr = ra[0][i+1]; m0_wstrb = rws[0][i+1]; m0_wdata = rwd[0][i+1]; end
                else m0_valid = 1'b0;
            end else begin
                if (i < 3) begin m1_addr = ra[1][i+1]; m1_wstrb = rws[1][i+1]; m1_wdata = rwd[1][i+1]; end
                else m1_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        v = $urandom();
        preload(16'h0012, v);
        m0_valid = 1'b1; m0_addr = 32'h0000_0048; m0_wstrb = 4'd0;
        step();
        n_checks++; if (ram_ce !== 1'b1 || ram_addr !== 16'h0012) $display("FAIL rstmid_issue got ce %b addr %h want 1 0012", ram_ce, ram_addr); else n_pass++;
        rst = 1'b1;
        m0_valid = 1'b0;
        step();
        n_checks++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) $display("FAIL rstmid_noready got %b%b want 00", m0_ready, m1_ready); else n_pass++;
        n_checks++; if (ram_ce !== 1'b0 || ram_wr !== 4'd0 || ram_addr !== 16'd0 || ram_d !== 32'd0) $display("FAIL rstmid_clear got ce %b wr %h addr %h d %h want all 0", ram_ce, ram_wr, ram_addr, ram_d); else n_pass++;
        rst = 1'b0;
        step();
        n_checks++; if (m0_ready !== 1'b0 || ram_ce !== 1'b0) $display("FAIL rstmid_quiet got rdy %b ce %b want 0 0", m0_ready, ram_ce); else n_pass++;
        m0_valid = 1'b1; m0_addr = 32'h0000_0048; m0_wstrb = 4'd0;
        step();
        n_checks++; if (ram_ce !== 1'b1 || m0_ready !== 1'b0) $display("FAIL rstmid_reissue got ce %b rdy %b want 1 0", ram_ce, m0_ready); else n_pass++;
        step();
        n_checks++; if (m0_ready !== 1'b1 || m0_rdata !== v) $display("FAIL rstmid_done got rdy %b data %h want 1 %h", m0_ready, m0_rdata, v); else n_pass++;
        m0_valid = 1'b0;
        step();
        n_checks++; if (m0_ready !== 1'b0) $display("FAIL rstmid_pulse got %b want 0", m0_ready); else n_pass++;
    endtask

    initial begin
        bd_en = 1'b0; bd_addr = 16'd0; bd_data = 32'd0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_byte_write();
        test_addr_mask();
        test_back_to_back();
        test_contention();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter and sequencer for the single-ported 64Ki x 32-bit on-chip RAM. It sits between the picorv32 native memory interface (port 0) and a secondary master such as the host loader or a DMA engine (port 1). It serialises their requests onto the RAM's `ce`/`wr`/`addr`/`d` inputs and returns the RAM's registered `q` with a one-cycle `ready` pulse. Every access is a fixed 3-cycle transaction, and ownership alternates when both ports contend.

## Interface
- `ADDR_W`, default 16: RAM word-address width; byte address bits `[ADDR_W+1:2]` select the word.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `m0_valid` input 1: port 0 request; held high until `m0_ready`.
- `m0_addr` input 32: port 0 byte address; bits `[1:0]` and above `ADDR_W+1` are ignored.
- `m0_wstrb` input 4: port 0 byte write enables; `0000` means read.
- `m0_wdata` input 32: port 0 write data.
- `m0_ready` output 1: one-cycle completion pulse for port 0.
- `m0_rdata` output 32: read data, valid while `m0_ready` is high.
- `m1_valid`, `m1_addr`, `m1_wstrb`, `m1_wdata`, `m1_ready`, `m1_rdata`: same as port 0, for port 1.
- `ram_ce` output 1: RAM enable.
- `ram_wr` output 4: RAM byte write enables.
- `ram_addr` output `ADDR_W`: RAM word address.
- `ram_d` output 32: RAM write data.
- `ram_q` input 32: RAM registered read data; updates one edge after `ram_ce`.

## Operation
- State machine `IDLE` -> `ISSUE` -> `DONE` -> `IDLE`, with no other transitions except reset.
- **IDLE:**
  - If no valid is high, stay in `IDLE`.
  - If exactly one valid is high, grant that port.
  - If both are high, grant the port that is not `last_grant`.
  - On grant, register `ram_addr`, `ram_wr`, `ram_d` from the granted port, set `ram_ce`=1, update `last_grant`, and go to `ISSUE`.
- **ISSUE:** `ram_ce` is high this cycle, so the RAM performs the read and/or byte-masked write. At the end of the cycle, register `ram_ce`=0 and `ram_wr`=0, and go to `DONE`.
- **DONE:**
  - Assert `mX_ready` for the granted port only.
  - `mX_rdata` = `ram_q`, combinational passthrough; both `rdata` outputs always carry `ram_q` and are meaningful only with their own ready.
  - Go to `IDLE`.
- Writes also complete with a ready pulse in `DONE`; `rdata` then returns the pre-write word (read-before-write RAM behaviour).
- Request fields are sampled only in `IDLE` at grant. Changes to `addr`/`wstrb`/`wdata`/`valid` after grant do not affect the transaction.
- If `valid` drops before `ready` (protocol violation), the transaction completes anyway and the ready pulse is still issued.
- The requester must deassert `valid` or present a new request in the cycle after `ready`. Because `IDLE` follows `DONE`, a still-high valid is re-arbitrated as a new request.
- Round-robin: `last_grant` resets to 1, so port 0 wins the first contended cycle. Neither port waits more than one transaction while the other is served.

## Timing
- Request sampled in `IDLE` at cycle N, `ram_ce` high in cycle N+1, ready high in cycle N+2. Latency is 2 cycles from valid to ready.
- Throughput: one access per 3 cycles; the next grant can occur in cycle N+3.
- Reset values: state `IDLE`, `ram_ce`=0, `ram_wr`=0, `ram_addr`=0, `ram_d`=0, `m0_ready`=`m1_ready`=0, `last_grant`=1. `rdata` follows `ram_q` and is not reset.
- Reset mid-transaction:
  - Outputs clear at the reset edge.
  - No ready pulse is issued for the aborted transaction.
  - A write whose `ram_ce` was already high in the reset cycle still completes in the RAM. The requester must reissue after reset.
- Ready is never asserted for both ports in the same cycle, and is never asserted for two consecutive cycles.

## Test plan
- Single read, port 0: preload word 0x0010 = 0xDEADBEEF; `m0_addr`=0x40, `wstrb`=0 in cycle 0. Expect `ram_ce` in cycle 1 only, `m0_ready` in cycle 2, `m0_rdata`=0xDEADBEEF, `m1_ready`=0 throughout.
- Byte write then read, port 1: write `m1_addr`=0x44, `wstrb`=0100, `wdata`=0x00AB0000 over old word 0x11223344. Then read back and expect 0x11AB3344; ready pulses at cycles 2 and 5.
- Contention: both ports valid continuously from reset, 4 transactions each. Expect grants alternating 0,1,0,1…, ready every 3 cycles, each port served 4 times.
- Back-to-back single port: `m0_valid` held with new addresses after each ready. Expect `ram_ce` every third cycle and no idle gap beyond `DONE`→`IDLE`.
- Reset mid-operation: `rst` asserted during `ISSUE` of a port 0 read. Expect no `m0_ready`, all RAM outputs 0 next cycle, and after release a fresh request completes normally with 2-cycle latency.
- Address masking: `m0_addr`=0xFFFC0043 reads word 0x0010 (same data as address 0x40).
